// File: rtl/urp_pcie_rx_tlp_router.sv
// RX TLP router: steers whole TLPs into per-traffic-class channel FIFOs and drains them round-robin
// into a registered header-decode stage. Define URP_RX_TLP_DROP_UNSUP_EN to drop and count unsupported types.
module urp_pcie_rx_tlp_router #(
   parameter int unsigned PAYLOAD_W = 128,
   parameter int unsigned N_CH      = 2,
   parameter int unsigned DEPTH_LG2 = 2,
   localparam int unsigned TLP_W    = 96 + PAYLOAD_W,
   localparam int unsigned CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [TLP_W-1:0]     s_tlp_i,
   input  logic                 s_valid_i,
   output logic                 s_ready_o,
   output logic                 m_valid_o,
   input  logic                 m_ready_i,
   output logic [CH_W-1:0]      m_ch_o,
   output logic [2:0]           m_fmt_o,
   output logic [4:0]           m_type_o,
   output logic [2:0]           m_tc_o,
   output logic [9:0]           m_length_o,
   output logic [15:0]          m_req_id_o,
   output logic [15:0]          m_cpl_id_o,
   output logic [31:0]          m_addr_o,
   output logic [PAYLOAD_W-1:0] m_payload_o,
   output logic                 m_unsup_o,
   output logic [N_CH-1:0]      ch_full_o,
   output logic [N_CH-1:0]      ch_empty_o,
   output logic [15:0]          drop_cnt_o
);

   localparam int unsigned DEPTH   = 1 << DEPTH_LG2;
   localparam int unsigned PTR_W   = DEPTH_LG2 + 1;
   localparam int unsigned DW0_LSB = TLP_W - 32;

   logic [TLP_W-1:0] fifo_mem [N_CH][DEPTH];
   logic [PTR_W-1:0] wr_ptr   [N_CH];
   logic [PTR_W-1:0] rd_ptr   [N_CH];
   logic [N_CH-1:0]  ch_full;
   logic [N_CH-1:0]  ch_empty;
   logic [2:0]       s_tc;
   logic [CH_W-1:0]  wr_ch;
   logic             wr_en;
   logic [CH_W-1:0]  rr_ptr;
   logic [CH_W-1:0]  grant;
   logic             grant_vld;
   logic             rd_en;
   logic [TLP_W-1:0] head;
   logic             head_rsvd_unused;

   function automatic logic [CH_W-1:0] ch_add(input logic [CH_W-1:0] base, input int unsigned off);
      return CH_W'((32'(base) + off) % N_CH);
   endfunction

   assign s_tc  = s_tlp_i[DW0_LSB+23 -: 3];
   assign wr_ch = CH_W'(32'(s_tc) % N_CH);

   // Pointers carry one wrap bit so full and empty are distinguishable.
   always_comb begin
      ch_full  = '0;
      ch_empty = '0;
      for (int unsigned i = 0; i < N_CH; i++) begin
         ch_empty[i] = (wr_ptr[i] == rd_ptr[i]);
         ch_full[i]  = (wr_ptr[i][PTR_W-1] != rd_ptr[i][PTR_W-1]) &&
                       (wr_ptr[i][PTR_W-2:0] == rd_ptr[i][PTR_W-2:0]);
      end
   end

   assign ch_full_o  = ch_full;
   assign ch_empty_o = ch_empty;

`ifdef URP_RX_TLP_DROP_UNSUP_EN
   logic s_unsup;

   assign s_unsup   = (s_tlp_i[DW0_LSB+28 -: 4] != 4'b0000) && (s_tlp_i[DW0_LSB+28 -: 4] != 4'b0101);
   assign s_ready_o = s_unsup || !ch_full[wr_ch];
   assign wr_en     = s_valid_i && s_ready_o && !s_unsup;
   assign m_unsup_o = 1'b0;

   // Unsupported TLPs are swallowed at the input; count them, saturating.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drop_cnt_o <= '0;
      end else if (s_valid_i && s_unsup && (drop_cnt_o != 16'hFFFF)) begin
         drop_cnt_o <= drop_cnt_o + 16'd1;
      end
   end
`else
   assign s_ready_o  = !ch_full[wr_ch];
   assign wr_en      = s_valid_i && s_ready_o;
   assign drop_cnt_o = '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_unsup_o <= 1'b0;
      end else if (rd_en) begin
         m_unsup_o <= (head[DW0_LSB+28 -: 4] != 4'b0000) && (head[DW0_LSB+28 -: 4] != 4'b0101);
      end
   end
`endif

   // Round-robin: first non-empty channel at or after rr_ptr.
   always_comb begin
      grant     = '0;
      grant_vld = 1'b0;
      for (int unsigned i = 0; i < N_CH; i++) begin
         if (!grant_vld && !ch_empty[ch_add(rr_ptr, i)]) begin
            grant     = ch_add(rr_ptr, i);
            grant_vld = 1'b1;
         end
      end
   end

   assign rd_en            = grant_vld && (!m_valid_o || m_ready_i);
   assign head             = fifo_mem[grant][rd_ptr[grant][DEPTH_LG2-1:0]];
   assign head_rsvd_unused = ^head[DW0_LSB+10:DW0_LSB];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         fifo_mem[wr_ch][wr_ptr[wr_ch][DEPTH_LG2-1:0]] <= s_tlp_i;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < N_CH; i++) begin
            wr_ptr[i] <= '0;
            rd_ptr[i] <= '0;
         end
         rr_ptr <= '0;
      end else begin
         if (wr_en) begin
            wr_ptr[wr_ch] <= wr_ptr[wr_ch] + PTR_W'(1);
         end
         if (rd_en) begin
            rd_ptr[grant] <= rd_ptr[grant] + PTR_W'(1);
            rr_ptr        <= (32'(grant) == N_CH - 1) ? '0 : grant + CH_W'(1);
         end
      end
   end

   // Output stage: load on the same edge as the FIFO pop, hold while stalled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_valid_o   <= 1'b0;
         m_ch_o      <= '0;
         m_fmt_o     <= '0;
         m_type_o    <= '0;
         m_tc_o      <= '0;
         m_length_o  <= '0;
         m_req_id_o  <= '0;
         m_cpl_id_o  <= '0;
         m_addr_o    <= '0;
         m_payload_o <= '0;
      end else if (rd_en) begin
         m_valid_o   <= 1'b1;
         m_ch_o      <= grant;
         m_fmt_o     <= head[DW0_LSB+31 -: 3];
         m_type_o    <= head[DW0_LSB+28 -: 5];
         m_tc_o      <= head[DW0_LSB+23 -: 3];
         m_length_o  <= head[DW0_LSB+20 -: 10];
         m_req_id_o  <= head[TLP_W-33 -: 16];
         m_cpl_id_o  <= head[TLP_W-49 -: 16];
         m_addr_o    <= head[TLP_W-65 -: 32];
         m_payload_o <= head[PAYLOAD_W-1:0];
      end else if (m_ready_i) begin
         m_valid_o   <= 1'b0;
      end
   end

endmodule
